// File: rtl/mat_result_streamer.sv
// Buffers one ROWS x COLS result matrix per handshake and replays it row-major,
// one element per beat, with last/row/col sidebands and a completed-matrix count.
module mat_result_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [0:ROWS-1][0:COLS-1][DATA_WIDTH-1:0] c_in,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    output logic [DATA_WIDTH-1:0]                     m_data,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic                                      m_last,
    output logic [RW-1:0]                             m_row,
    output logic [CW-1:0]                             m_col,
    output logic [31:0]                               mat_count
);

    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                                    state_q, state_d;
    logic [RW-1:0]                             row_q, row_d;
    logic [CW-1:0]                             col_q, col_d;
    logic [31:0]                               mat_count_q, mat_count_d;
    logic [0:ROWS-1][0:COLS-1][DATA_WIDTH-1:0] buf_q;

    logic at_last;
    logic xfer;
    logic last_xfer;
    logic capture;

    // A new matrix may land on the same edge the old one's last beat leaves.
    always_comb begin
        at_last   = (state_q == SEND) && (row_q == LAST_ROW) && (col_q == LAST_COL);
        xfer      = (state_q == SEND) && m_ready;
        last_xfer = xfer && at_last;
        in_ready  = (state_q == IDLE) || last_xfer;
        capture   = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = SEND;
            SEND:    if (last_xfer && !capture) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        row_d       = row_q;
        col_d       = col_q;
        mat_count_d = mat_count_q;
        if (capture || last_xfer) begin
            row_d = '0;
            col_d = '0;
        end else if (xfer) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
        if (last_xfer) begin
            mat_count_d = mat_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q       <= '0;
            col_q       <= '0;
            mat_count_q <= '0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            mat_count_q <= mat_count_d;
        end
    end

    // Buffer contents are irrelevant until a capture, so no reset here.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_q <= c_in;
        end
    end

    always_comb begin
        m_valid   = (state_q == SEND);
        m_last    = at_last;
        m_row     = row_q;
        m_col     = col_q;
        m_data    = m_valid ? buf_q[row_q][col_q] : '0;
        mat_count = mat_count_q;
    end

endmodule

// File: tb/tb_mat_result_streamer.sv
// Bench for mat_result_streamer: a queue-based element model checks a 4x4 instance
// every cycle; a 1x1 instance is exercised with directed back-to-back matrices.
module tb_mat_result_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [0:3][0:3][31:0]  c_in;
    logic                   in_valid, in_ready, m_valid, m_ready, m_last;
    logic [31:0]            m_data, mat_count;
    logic [1:0]             m_row, m_col;

    logic [0:0][0:0][31:0]  c1;
    logic                   v1, rdy1, mv1, mr1, ml1;
    logic [31:0]            md1, mc1;
    logic [0:0]             row1, col1;

    mat_result_streamer #(.DATA_WIDTH(32), .ROWS(4), .COLS(4)) dut (
        .clk(clk), .rst(rst), .c_in(c_in), .in_valid(in_valid), .in_ready(in_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .m_row(m_row), .m_col(m_col), .mat_count(mat_count)
    );

    mat_result_streamer #(.DATA_WIDTH(32), .ROWS(1), .COLS(1)) dut1 (
        .clk(clk), .rst(rst), .c_in(c1), .in_valid(v1), .in_ready(rdy1),
        .m_data(md1), .m_valid(mv1), .m_ready(mr1), .m_last(ml1),
        .m_row(row1), .m_col(col1), .mat_count(mc1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the outstanding elements of the buffered matrix, in stream order.
    typedef struct {
        logic [31:0] d;
        int          r;
        int          c;
    } el_t;

    el_t         q[$];
    logic [31:0] seen[$];
    logic [31:0] mcount = 0;
    int          xfers = 0;
    bit          started = 0;
    bit          after_rst = 0;
    bit          exp_ready;
    el_t         e;

    always @(negedge clk) begin
        if (started) begin
            exp_ready = (q.size() == 0) || (q.size() == 1 && m_ready);
            chk("in_ready", in_ready, exp_ready);
            chk("m_valid", m_valid, q.size() > 0);
            chk("mat_count", mat_count, mcount);
            if (q.size() > 0) begin
                chk("m_data", m_data, q[0].d);
                chk("m_row", m_row, q[0].r);
                chk("m_col", m_col, q[0].c);
                chk("m_last", m_last, q.size() == 1);
            end
            if (after_rst) begin
                chk("rst_m_data", m_data, 0);
                chk("rst_m_last", m_last, 0);
                chk("rst_m_row", m_row, 0);
                chk("rst_m_col", m_col, 0);
            end
        end
        after_rst = 0;
        if (rst) begin
            q.delete();
            mcount    = 0;
            after_rst = 1;
            started   = 1;
        end else if (started) begin
            exp_ready = (q.size() == 0) || (q.size() == 1 && m_ready);
            if (q.size() > 0 && m_ready) begin
                seen.push_back(q[0].d);
                if (q.size() == 1) mcount = mcount + 1;
                void'(q.pop_front());
                xfers++;
            end
            if (in_valid && exp_ready) begin
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        e.d = c_in[i][j];
                        e.r = i;
                        e.c = j;
                        q.push_back(e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int base);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                c_in[i][j] = 32'(base + 4 * i + j);
    endtask

    // Advance until the model has seen `target` transfers; mode 0 ready high,
    // 1 ready pattern 1,0,0,1, 2 random ready.
    task automatic run(input int target, input int mode, input int budget);
        int n = 0;
        int k = 0;
        while (xfers < target && n < budget) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (k % 4 == 0) || (k % 4 == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            k++;
            step();
            n++;
        end
        if (xfers < target) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d transfers expected %0d", xfers, target);
        end
        m_ready = 1'b1;
    endtask

    int x0;

    initial begin
        rst = 1'b1; in_valid = 1'b0; m_ready = 1'b1; c_in = '0;
        c1 = '0; v1 = 1'b0; mr1 = 1'b0;
        step(); step();
        rst = 1'b0;
        step();

        // Single matrix, ready held high.
        x0 = xfers;
        load(0); in_valid = 1'b1; step(); in_valid = 1'b0;
        run(x0 + 16, 0, 100);
        chk("t1_count", mat_count, 1);
        chk("t1_ready", in_ready, 1);
        chk("t1_first", seen[x0], 0);
        chk("t1_fifth", seen[x0 + 4], 4);
        chk("t1_lastv", seen[x0 + 15], 15);

        // Stalling sink.
        x0 = xfers;
        load(0); in_valid = 1'b1; step(); in_valid = 1'b0;
        run(x0 + 16, 1, 200);
        chk("t2_count", mat_count, 2);
        chk("t2_lastv", seen[x0 + 15], 15);

        // Back-to-back matrices with in_valid held high.
        x0 = xfers;
        load(0); in_valid = 1'b1; m_ready = 1'b1; step();
        load(100);
        repeat (16) step();
        in_valid = 1'b0;
        run(x0 + 32, 0, 100);
        chk("t3_count", mat_count, 4);
        chk("t3_second_first", seen[x0 + 16], 100);
        chk("t3_second_last", seen[x0 + 31], 115);

        // Input changes after capture must not leak into the stream.
        x0 = xfers;
        load(0); in_valid = 1'b1; step(); in_valid = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                c_in[i][j] = 32'hDEADBEEF;
        run(x0 + 16, 0, 100);
        chk("t4_count", mat_count, 5);
        chk("t4_mid", seen[x0 + 7], 7);

        // Reset mid-stream.
        x0 = xfers;
        load(0); in_valid = 1'b1; step(); in_valid = 1'b0;
        run(x0 + 5, 0, 50);
        rst = 1'b1; step(); rst = 1'b0;
        chk("t5_count", mat_count, 0);
        chk("t5_valid", m_valid, 0);
        chk("t5_ready", in_ready, 1);
        x0 = xfers;
        load(200); in_valid = 1'b1; step(); in_valid = 1'b0;
        run(x0 + 16, 0, 100);
        chk("t5_first", seen[x0], 200);
        chk("t5_lastv", seen[x0 + 15], 215);
        chk("t5_count2", mat_count, 1);

        // Random traffic against the model.
        repeat (3000) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    c_in[i][j] = $urandom;
            in_valid = ($urandom_range(0, 2) == 0);
            m_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0; m_ready = 1'b1;
        repeat (20) step();
        chk("rand_drained", m_valid, 0);

        // 1x1 matrices back to back.
        c1[0][0] = 32'd7; v1 = 1'b1; mr1 = 1'b1;
        step();
        c1[0][0] = 32'd9;
        @(negedge clk);
        chk("s1_valid0", mv1, 1);
        chk("s1_data0", md1, 7);
        chk("s1_last0", ml1, 1);
        chk("s1_ready0", rdy1, 1);
        step();
        v1 = 1'b0; c1[0][0] = 32'd5;
        @(negedge clk);
        chk("s1_valid1", mv1, 1);
        chk("s1_data1", md1, 9);
        chk("s1_last1", ml1, 1);
        chk("s1_count1", mc1, 1);
        step();
        @(negedge clk);
        chk("s1_valid2", mv1, 0);
        chk("s1_count2", mc1, 2);
        chk("s1_ready2", rdy1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
